// File: rtl/axi_master_if.sv
// rtl/axi_master_if.sv - handshake request port and AXI4-Lite bus bundle for axi_master
interface axi_master_if;
    // Initiator handshake port
    logic        hs_read_i;
    logic        hs_write_i;
    logic [31:0] hs_addr_i;
    logic [31:0] hs_data_i;
    logic [3:0]  byte_select_i;
    logic        hs_ready_o;
    logic [31:0] hs_data_o;
    logic        hs_err_o;
    // AR channel
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] araddr_o;
    // R channel
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    // AW channel
    logic        awvalid_o;
    logic        awready_i;
    logic [31:0] awaddr_o;
    // W channel
    logic        wvalid_o;
    logic        wready_i;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    // B channel
    logic        bvalid_i;
    logic        bready_o;
    logic [1:0]  bresp_i;

    modport master (
        input  hs_read_i, hs_write_i, hs_addr_i, hs_data_i, byte_select_i,
        output hs_ready_o, hs_data_o, hs_err_o,
        output arvalid_o, araddr_o, input arready_i,
        input  rvalid_i, rdata_i, rresp_i, output rready_o,
        output awvalid_o, awaddr_o, input awready_i,
        output wvalid_o, wdata_o, wstrb_o, input wready_i,
        input  bvalid_i, bresp_i, output bready_o
    );

    modport slave (
        output hs_read_i, hs_write_i, hs_addr_i, hs_data_i, byte_select_i,
        input  hs_ready_o, hs_data_o, hs_err_o,
        input  arvalid_o, araddr_o, output arready_i,
        output rvalid_i, rdata_i, rresp_i, input rready_o,
        input  awvalid_o, awaddr_o, output awready_i,
        input  wvalid_o, wdata_o, wstrb_o, output wready_i,
        output bvalid_i, bresp_i, input bready_o
    );
endinterface

// File: rtl/axi_master.sv
// rtl/axi_master.sv - single-outstanding AXI4-Lite master from a level handshake; AXI_MASTER_RESP_CHECK_EN enables hs_err_o
module axi_master (
    input  logic            clk_i,
    input  logic            rst_i,
    axi_master_if.master    bus
);
    typedef enum logic [2:0] {IDLE, AR, R, WR, B, RESP} state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic        ready_q;
    logic        err_q;
    logic        aw_done;
    logic        w_done;

    logic        aw_fire;
    logic        w_fire;
    logic        aw_done_nx;
    logic        w_done_nx;
    logic        r_err;
    logic        b_err;

    // Channel handshakes and the completion view including the current cycle
    assign aw_fire    = awvalid_q & bus.awready_i;
    assign w_fire     = wvalid_q  & bus.wready_i;
    assign aw_done_nx = aw_done | aw_fire;
    assign w_done_nx  = w_done  | w_fire;

`ifdef AXI_MASTER_RESP_CHECK_EN
    // SLVERR/DECERR (any non-OKAY response) flags an error
    assign r_err = |bus.rresp_i;
    assign b_err = |bus.bresp_i;
`else
    // Responses are ignored; the error flop stays at its reset value
    logic unused_resp;
    assign unused_resp = ^{bus.rresp_i, bus.bresp_i};
    assign r_err = 1'b0;
    assign b_err = 1'b0;
`endif

    // Transaction FSM with registered AXI and handshake outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Reads win when both requests are present
                    if (bus.hs_read_i) begin
                        state     <= AR;
                        arvalid_q <= 1'b1;
                        addr_q    <= bus.hs_addr_i;
                        wdata_q   <= bus.hs_data_i;
                        wstrb_q   <= bus.byte_select_i;
                    end else if (bus.hs_write_i) begin
                        state     <= WR;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        addr_q    <= bus.hs_addr_i;
                        wdata_q   <= bus.hs_data_i;
                        wstrb_q   <= bus.byte_select_i;
                    end
                end
                AR: begin
                    if (bus.arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= R;
                    end
                end
                R: begin
                    if (bus.rvalid_i) begin
                        rready_q <= 1'b0;
                        rdata_q  <= bus.rdata_i;
                        err_q    <= r_err;
                        ready_q  <= 1'b1;
                        state    <= RESP;
                    end
                end
                WR: begin
                    // AW and W complete independently, in any order
                    if (aw_fire) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if (aw_done_nx && w_done_nx) begin
                        bready_q <= 1'b1;
                        state    <= B;
                    end
                end
                B: begin
                    if (bus.bvalid_i) begin
                        bready_q <= 1'b0;
                        err_q    <= b_err;
                        ready_q  <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.arvalid_o  = arvalid_q;
    assign bus.araddr_o   = addr_q;
    assign bus.rready_o   = rready_q;
    assign bus.awvalid_o  = awvalid_q;
    assign bus.awaddr_o   = addr_q;
    assign bus.wvalid_o   = wvalid_q;
    assign bus.wdata_o    = wdata_q;
    assign bus.wstrb_o    = wstrb_q;
    assign bus.bready_o   = bready_q;
    assign bus.hs_ready_o = ready_q;
    assign bus.hs_data_o  = rdata_q;
    assign bus.hs_err_o   = err_q;
endmodule

// File: tb/tb_axi_master.sv
// tb/tb_axi_master.sv - directed self-checking bench for axi_master
module tb_axi_master;
    logic clk_i;
    logic rst_i;
    int   errors;
    int   checks;

    axi_master_if bus ();

    axi_master dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.master)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

`ifdef AXI_MASTER_RESP_CHECK_EN
    localparam logic EXP_BERR = 1'b1;
`else
    localparam logic EXP_BERR = 1'b0;
`endif

    task automatic clear_inputs();
        bus.hs_read_i     = 1'b0;
        bus.hs_write_i    = 1'b0;
        bus.hs_addr_i     = '0;
        bus.hs_data_i     = '0;
        bus.byte_select_i = '0;
        bus.arready_i     = 1'b0;
        bus.rvalid_i      = 1'b0;
        bus.rdata_i       = '0;
        bus.rresp_i       = '0;
        bus.awready_i     = 1'b0;
        bus.wready_i      = 1'b0;
        bus.bvalid_i      = 1'b0;
        bus.bresp_i       = '0;
    endtask

    task automatic test_reset();
        logic [5:0] ctl;
        rst_i = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk_i);
        ctl = {bus.arvalid_o, bus.rready_o, bus.awvalid_o, bus.wvalid_o, bus.bready_o, bus.hs_ready_o};
        checks++;
        if (ctl !== 6'b0) begin
            errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 6'b0);
        end
        checks++;
        if (bus.hs_data_o !== 32'h0 || bus.hs_err_o !== 1'b0) begin
            errors++; $display("FAIL reset_data got=%h/%b exp=0/0", bus.hs_data_o, bus.hs_err_o);
        end
        checks++;
        if (bus.araddr_o !== 32'h0 || bus.wdata_o !== 32'h0 || bus.wstrb_o !== 4'h0) begin
            errors++; $display("FAIL reset_regs got=%h/%h/%h exp=0", bus.araddr_o, bus.wdata_o, bus.wstrb_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_read();
        bus.hs_read_i = 1'b1;
        bus.hs_addr_i = 32'h0000_0010;
        @(negedge clk_i); // cycle 1
        checks++;
        if (bus.arvalid_o !== 1'b1 || bus.araddr_o !== 32'h10) begin
            errors++; $display("FAIL rd_ar got=%b/%h exp=1/00000010", bus.arvalid_o, bus.araddr_o);
        end
        bus.arready_i = 1'b1;
        @(negedge clk_i); // cycle 2
        checks++;
        if (bus.arvalid_o !== 1'b0 || bus.rready_o !== 1'b1 || bus.hs_ready_o !== 1'b0) begin
            errors++; $display("FAIL rd_r got=%b%b%b exp=010", bus.arvalid_o, bus.rready_o, bus.hs_ready_o);
        end
        bus.arready_i = 1'b0;
        bus.rvalid_i  = 1'b1;
        bus.rdata_i   = 32'hDEAD_BEEF;
        @(negedge clk_i); // cycle 3
        checks++;
        if (bus.hs_ready_o !== 1'b1 || bus.hs_data_o !== 32'hDEAD_BEEF || bus.hs_err_o !== 1'b0) begin
            errors++; $display("FAIL rd_resp got=%b/%h/%b exp=1/deadbeef/0", bus.hs_ready_o, bus.hs_data_o, bus.hs_err_o);
        end
        bus.rvalid_i  = 1'b0;
        bus.hs_read_i = 1'b0;
        @(negedge clk_i); // cycle 4
        checks++;
        if (bus.hs_ready_o !== 1'b0 || bus.arvalid_o !== 1'b0 || bus.hs_data_o !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rd_idle got=%b/%b/%h exp=0/0/deadbeef", bus.hs_ready_o, bus.arvalid_o, bus.hs_data_o);
        end
    endtask

    task automatic test_write_w_first();
        bus.hs_write_i    = 1'b1;
        bus.hs_addr_i     = 32'h20;
        bus.hs_data_i     = 32'h1234_5678;
        bus.byte_select_i = 4'h3;
        @(negedge clk_i); // cycle 1
        checks++;
        if (bus.awvalid_o !== 1'b1 || bus.wvalid_o !== 1'b1 || bus.awaddr_o !== 32'h20 ||
            bus.wdata_o !== 32'h1234_5678 || bus.wstrb_o !== 4'h3) begin
            errors++; $display("FAIL wr_issue got=%b%b/%h/%h/%h exp=11/00000020/12345678/3",
                bus.awvalid_o, bus.wvalid_o, bus.awaddr_o, bus.wdata_o, bus.wstrb_o);
        end
        bus.wready_i = 1'b1;
        @(negedge clk_i); // cycle 2
        bus.wready_i = 1'b0;
        for (int c = 2; c <= 3; c++) begin
            checks++;
            if (bus.awvalid_o !== 1'b1 || bus.wvalid_o !== 1'b0 || bus.bready_o !== 1'b0 ||
                bus.awaddr_o !== 32'h20 || bus.wstrb_o !== 4'h3) begin
                errors++; $display("FAIL wr_wait_aw c=%0d got=%b%b%b exp=100", c, bus.awvalid_o, bus.wvalid_o, bus.bready_o);
            end
            if (c == 3) bus.awready_i = 1'b1;
            else @(negedge clk_i);
        end
        @(negedge clk_i); // cycle 4
        checks++;
        if (bus.awvalid_o !== 1'b0 || bus.bready_o !== 1'b1 || bus.hs_ready_o !== 1'b0) begin
            errors++; $display("FAIL wr_b got=%b%b%b exp=010", bus.awvalid_o, bus.bready_o, bus.hs_ready_o);
        end
        bus.awready_i = 1'b0;
        bus.bvalid_i  = 1'b1;
        bus.bresp_i   = 2'b00;
        @(negedge clk_i); // cycle 5
        checks++;
        if (bus.hs_ready_o !== 1'b1 || bus.hs_err_o !== 1'b0 || bus.bready_o !== 1'b0 ||
            bus.hs_data_o !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_resp got=%b/%b/%b/%h exp=1/0/0/deadbeef",
                bus.hs_ready_o, bus.hs_err_o, bus.bready_o, bus.hs_data_o);
        end
        bus.bvalid_i   = 1'b0;
        bus.hs_write_i = 1'b0;
        @(negedge clk_i); // cycle 6
        checks++;
        if (bus.hs_ready_o !== 1'b0) begin
            errors++; $display("FAIL wr_single_pulse got=%b exp=0", bus.hs_ready_o);
        end
    endtask

    task automatic test_read_priority();
        bus.hs_read_i     = 1'b1;
        bus.hs_write_i    = 1'b1;
        bus.hs_addr_i     = 32'h30;
        bus.hs_data_i     = 32'hA5A5_A5A5;
        bus.byte_select_i = 4'hF;
        @(negedge clk_i); // cycle 1
        checks++;
        if (bus.arvalid_o !== 1'b1 || bus.awvalid_o !== 1'b0 || bus.wvalid_o !== 1'b0) begin
            errors++; $display("FAIL prio_read_first got=%b%b%b exp=100", bus.arvalid_o, bus.awvalid_o, bus.wvalid_o);
        end
        bus.arready_i = 1'b1;
        @(negedge clk_i); // cycle 2
        bus.arready_i = 1'b0;
        bus.rvalid_i  = 1'b1;
        bus.rdata_i   = 32'h0BAD_F00D;
        @(negedge clk_i); // cycle 3
        checks++;
        if (bus.hs_ready_o !== 1'b1 || bus.hs_data_o !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL prio_read_resp got=%b/%h exp=1/0badf00d", bus.hs_ready_o, bus.hs_data_o);
        end
        bus.rvalid_i  = 1'b0;
        bus.hs_read_i = 1'b0;
        @(negedge clk_i); // cycle 4: IDLE with write pending
        checks++;
        if (bus.awvalid_o !== 1'b0 || bus.arvalid_o !== 1'b0 || bus.hs_ready_o !== 1'b0) begin
            errors++; $display("FAIL prio_idle got=%b%b%b exp=000", bus.awvalid_o, bus.arvalid_o, bus.hs_ready_o);
        end
        @(negedge clk_i); // cycle 5
        checks++;
        if (bus.awvalid_o !== 1'b1 || bus.wvalid_o !== 1'b1 || bus.awaddr_o !== 32'h30 ||
            bus.wdata_o !== 32'hA5A5_A5A5 || bus.wstrb_o !== 4'hF) begin
            errors++; $display("FAIL prio_write_follows got=%b%b/%h/%h/%h exp=11/00000030/a5a5a5a5/f",
                bus.awvalid_o, bus.wvalid_o, bus.awaddr_o, bus.wdata_o, bus.wstrb_o);
        end
        bus.awready_i = 1'b1;
        bus.wready_i  = 1'b1;
        @(negedge clk_i); // cycle 6
        checks++;
        if (bus.bready_o !== 1'b1 || bus.awvalid_o !== 1'b0 || bus.wvalid_o !== 1'b0) begin
            errors++; $display("FAIL prio_same_cycle_b got=%b%b%b exp=100", bus.bready_o, bus.awvalid_o, bus.wvalid_o);
        end
        bus.awready_i = 1'b0;
        bus.wready_i  = 1'b0;
        bus.bvalid_i  = 1'b1;
        @(negedge clk_i); // cycle 7
        checks++;
        if (bus.hs_ready_o !== 1'b1 || bus.hs_data_o !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL prio_write_resp got=%b/%h exp=1/0badf00d", bus.hs_ready_o, bus.hs_data_o);
        end
        bus.bvalid_i   = 1'b0;
        bus.hs_write_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_stall();
        bus.hs_read_i = 1'b1;
        bus.hs_addr_i = 32'h44;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_i);
            if (c <= 4) begin
                checks++;
                if (bus.arvalid_o !== 1'b1 || bus.araddr_o !== 32'h44) begin
                    errors++; $display("FAIL stall_ar c=%0d got=%b/%h exp=1/00000044", c, bus.arvalid_o, bus.araddr_o);
                end
                bus.arready_i = (c == 4);
            end else if (c <= 7) begin
                checks++;
                if (bus.rready_o !== 1'b1 || bus.arvalid_o !== 1'b0) begin
                    errors++; $display("FAIL stall_r c=%0d got=%b%b exp=10", c, bus.rready_o, bus.arvalid_o);
                end
                bus.arready_i = 1'b0;
                bus.rvalid_i  = (c == 7);
                bus.rdata_i   = (c == 7) ? 32'h55AA_55AA : 32'hFFFF_FFFF;
            end
            if (c < 8) begin
                checks++;
                if (bus.hs_ready_o !== 1'b0) begin
                    errors++; $display("FAIL stall_early_ready c=%0d got=%b exp=0", c, bus.hs_ready_o);
                end
            end else begin
                checks++;
                if (bus.hs_ready_o !== 1'b1 || bus.hs_data_o !== 32'h55AA_55AA) begin
                    errors++; $display("FAIL stall_resp got=%b/%h exp=1/55aa55aa", bus.hs_ready_o, bus.hs_data_o);
                end
                bus.rvalid_i  = 1'b0;
                bus.hs_read_i = 1'b0;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic test_bresp_err();
        bus.hs_write_i = 1'b1;
        bus.hs_addr_i  = 32'h50;
        @(negedge clk_i);
        bus.awready_i = 1'b1;
        bus.wready_i  = 1'b1;
        @(negedge clk_i);
        bus.awready_i = 1'b0;
        bus.wready_i  = 1'b0;
        bus.bvalid_i  = 1'b1;
        bus.bresp_i   = 2'b10;
        @(negedge clk_i);
        checks++;
        if (bus.hs_ready_o !== 1'b1 || bus.hs_err_o !== EXP_BERR) begin
            errors++; $display("FAIL bresp_err got=%b/%b exp=1/%b", bus.hs_ready_o, bus.hs_err_o, EXP_BERR);
        end
        bus.bvalid_i   = 1'b0;
        bus.bresp_i    = 2'b00;
        bus.hs_write_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_reset_in_b();
        int pulses;
        pulses = 0;
        bus.hs_write_i = 1'b1;
        bus.hs_addr_i  = 32'h60;
        bus.hs_data_i  = 32'hCAFE_0001;
        @(negedge clk_i);
        bus.awready_i = 1'b1;
        bus.wready_i  = 1'b1;
        @(negedge clk_i);
        bus.awready_i  = 1'b0;
        bus.wready_i   = 1'b0;
        bus.hs_write_i = 1'b0;
        checks++;
        if (bus.bready_o !== 1'b1) begin
            errors++; $display("FAIL rstb_in_b got=%b exp=1", bus.bready_o);
        end
        #1 rst_i = 1'b0;
        #1;
        checks++;
        if (bus.bready_o !== 1'b0 || bus.hs_ready_o !== 1'b0) begin
            errors++; $display("FAIL rstb_async got=%b%b exp=00", bus.bready_o, bus.hs_ready_o);
        end
        bus.bvalid_i = 1'b1;
        @(negedge clk_i);
        bus.bvalid_i = 1'b0;
        rst_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            if (bus.hs_ready_o === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL rstb_no_ready got=%0d exp=0", pulses);
        end
        checks++;
        if (bus.hs_data_o !== 32'h0 || bus.araddr_o !== 32'h0 || bus.wdata_o !== 32'h0 ||
            {bus.arvalid_o, bus.awvalid_o, bus.wvalid_o, bus.rready_o, bus.bready_o} !== 5'b0) begin
            errors++; $display("FAIL rstb_idle got=%h/%h/%h/%b exp=0/0/0/00000", bus.hs_data_o, bus.araddr_o, bus.wdata_o,
                {bus.arvalid_o, bus.awvalid_o, bus.wvalid_o, bus.rready_o, bus.bready_o});
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_read();
        test_write_w_first();
        test_read_priority();
        test_stall();
        test_bresp_err();
        test_reset_in_b();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
